// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Serial receive front-end for the PWM control path. Oversamples UART_RXD at
//   16x baud, decodes 8N1 frames and queues good bytes in a show-ahead FIFO
//   that a command consumer drains with a valid/ready handshake.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz
//   BAUD        serial bit rate
//   FIFO_DEPTH  byte entries, power of two and >= 2
//
// Ports
//   CLK        in   system clock, single domain
//   RST        in   asynchronous active-high reset
//   UART_RXD   in   asynchronous serial line, idle high
//   RX_DATA    out  byte at the FIFO head, meaningful while RX_VALID=1
//   RX_VALID   out  FIFO not empty
//   RX_READY   in   consumer takes the head byte when RX_VALID & RX_READY
//   FRAME_ERR  out  one-cycle pulse, stop bit sampled low
//   OVERRUN    out  one-cycle pulse, good byte dropped on a full FIFO
//   RX_BUSY    out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_RXD,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
   output logic       RX_BUSY
);

   localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
   localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic             sync1, rxd_sync, prev;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       sub;
   logic [2:0]       bit_idx;
   logic [1:0]       state;
   logic [7:0]       shreg;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;

   logic tick, start_det, stop_pt, full, empty, pop, push;

   // Synchroniser flops reset high so a reset never looks like a start edge
   // on an idle line.
   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1    <= 1'b1;
         rxd_sync <= 1'b1;
         prev     <= 1'b1;
      end else begin
         sync1    <= UART_RXD;
         rxd_sync <= sync1;
         prev     <= rxd_sync;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      tick      = 1'b0;
      start_det = 1'b0;
      stop_pt   = 1'b0;
      full      = 1'b0;
      empty     = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;

      tick      = (cnt == CNT_W'(TICK_DIV - 1));
      // Edge detect rather than level detect: a held-low break line has
      // prev=0 and never starts a frame until it has gone high again.
      start_det = (state == ST_IDLE) && prev && !rxd_sync;
      stop_pt   = (state == ST_STOP) && tick && (sub == 4'd15);
      empty     = (wr_ptr == rd_ptr);
      full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop       = !empty && RX_READY;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push      = stop_pt && rxd_sync && (!full || pop);
   end

   // Oversample tick; realigned to the start edge so sample points are
   // measured from detection rather than from a free-running phase.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (start_det || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         sub       <= 4'd0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_det) begin
                  state <= ST_START;
                  sub   <= 4'd0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (sub == 4'd7) begin
                     // Mid start bit: a line already back high was a glitch.
                     sub     <= 4'd0;
                     bit_idx <= 3'd0;
                     state   <= rxd_sync ? ST_IDLE : ST_DATA;
                  end else begin
                     sub <= sub + 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  sub <= sub + 4'd1;
                  if (sub == 4'd15) begin
                     shreg   <= {rxd_sync, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7)
                        state <= ST_STOP;
                  end
               end
            end
            default: begin
               if (tick) begin
                  sub <= sub + 4'd1;
                  if (sub == 4'd15) begin
                     // Back to IDLE mid stop bit so a back-to-back start edge
                     // at the end of this stop bit is caught.
                     state <= ST_IDLE;
                     if (!rxd_sync)
                        FRAME_ERR <= 1'b1;
                     else if (full && !pop)
                        OVERRUN <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; validity is defined entirely by
   // the pointers, and leaving it unreset lets it map onto plain RAM/LUTs.
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= shreg;
   end

   assign RX_VALID = !empty;
   assign RX_DATA  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign RX_BUSY  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Scoreboard bench. Expected bytes are queued when a frame is issued; a
//   monitor pops and compares on every RX_VALID & RX_READY cycle. One DUT runs
//   at default parameters for the absolute latency check, a second runs with
//   TICK_DIV=4 so the remaining scenarios stay short.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int  F_CLK_HZ = 7372800;
   localparam int  F_BAUD   = 115200;
   localparam int  F_TICK   = F_CLK_HZ / (F_BAUD * 16);  // 4
   localparam int  STOP_LAT = 152 * F_TICK;              // detection -> stop sample
   localparam real F_BIT_NS = 16.0 * F_TICK * 20.0;      // 1280 ns, 64 clocks
   localparam real D_BIT_NS = 1.0e9 / 115200.0;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst, rxd, rx_ready, rxd_d, ready_d;
   logic [7:0] rx_data, rx_data_d;
   logic       rx_valid, frame_err, overrun, rx_busy;
   logic       rx_valid_d, frame_err_d, overrun_d, rx_busy_d;

   uart_rx_fifo #(.CLK_HZ(F_CLK_HZ), .BAUD(F_BAUD), .FIFO_DEPTH(4)) dut (
      .CLK(clk), .RST(rst), .UART_RXD(rxd),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
      .FRAME_ERR(frame_err), .OVERRUN(overrun), .RX_BUSY(rx_busy)
   );

   uart_rx_fifo dut_d (
      .CLK(clk), .RST(rst), .UART_RXD(rxd_d),
      .RX_DATA(rx_data_d), .RX_VALID(rx_valid_d), .RX_READY(ready_d),
      .FRAME_ERR(frame_err_d), .OVERRUN(overrun_d), .RX_BUSY(rx_busy_d)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;
   int n_ferr = 0, n_ovr = 0, ferr_cyc = 0, ovr_cyc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) begin n_ferr++; ferr_cyc = cyc; end
         if (overrun)   begin n_ovr++;  ovr_cyc  = cyc; end
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL pop_unexpected: got 0x%02h, expected no byte (cycle %0d)", rx_data, cyc);
            end else begin
               exp_b = exp_q.pop_front();
               check("pop_data", {24'h0, rx_data}, {24'h0, exp_b});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int   fall_cyc;
   event fall_ev;

   task automatic set_line(input bit to_d, input logic v);
      if (to_d) rxd_d = v;
      else      rxd   = v;
   endtask

   // Start edge is placed 1 ns after a rising clock edge, so the pin is low
   // from cycle fall_cyc and detection happens in cycle fall_cyc+2.
   task automatic send_frame(input bit to_d, input logic [7:0] b, input real bit_ns,
                             input logic stop_val);
      @(posedge clk);
      #1;
      set_line(to_d, 1'b0);
      fall_cyc = cyc;
      -> fall_ev;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         set_line(to_d, b[i]);
         #(bit_ns);
      end
      set_line(to_d, stop_val);
      #(bit_ns);
      set_line(to_d, 1'b1);
   endtask

   task automatic at_cycle(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, expected completion by 3 ms");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int t, t0, rise, k, ferr0, ovr0;
      real bit_ns;
      logic [7:0] b;

      rst = 1'b1; rxd = 1'b1; rxd_d = 1'b1; rx_ready = 1'b0; ready_d = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid",   rx_valid,  0);
      check("reset_busy",    rx_busy,   0);
      check("reset_ferr",    frame_err, 0);
      check("reset_overrun", overrun,   0);
      check("reset_valid_d", rx_valid_d, 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);

      // Single byte at default parameters: absolute latency and pop timing.
      rise = -1;
      t0 = 0;
      fork
         send_frame(1'b1, 8'h55, D_BIT_NS, 1'b1);
         begin
            @(fall_ev);
            t0 = fall_cyc;
            k = 0;
            while (!rx_valid_d && k < 6000) begin
               @(negedge clk);
               k++;
            end
            rise = cyc;
         end
      join
      check("latency_detect_to_valid", rise - (t0 + 2), 4105);
      check("single_data", rx_data_d, 8'h55);
      @(posedge clk); #1 ready_d = 1'b1;
      @(negedge clk);
      check("single_valid_before_pop", rx_valid_d, 1);
      @(posedge clk); #1 ready_d = 1'b0;
      @(negedge clk);
      check("single_valid_after_pop", rx_valid_d, 0);

      // Back-to-back, consumer always ready.
      ferr0 = n_ferr; ovr0 = n_ovr;
      rx_ready = 1'b1;
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hA5);
      send_frame(1'b0, 8'h00, F_BIT_NS, 1'b1);
      send_frame(1'b0, 8'hFF, F_BIT_NS, 1'b1);
      send_frame(1'b0, 8'hA5, F_BIT_NS, 1'b1);
      wait_drain("b2b_drain", 200);
      check("b2b_ferr", n_ferr - ferr0, 0);
      check("b2b_overrun", n_ovr - ovr0, 0);

      // Glitch: 100 ns low pulse on an idle line.
      ferr0 = n_ferr;
      @(posedge clk); #1 rxd = 1'b0;
      t = cyc;
      fork
         begin repeat (5) @(posedge clk); #1 rxd = 1'b1; end
         begin
            at_cycle(t + 3);
            check("glitch_busy_rise", rx_busy, 1);
            at_cycle(t + 2 + 8 * F_TICK);
            check("glitch_busy_hold", rx_busy, 1);
            at_cycle(t + 3 + 8 * F_TICK);
            check("glitch_busy_fall", rx_busy, 0);
         end
      join
      repeat (20) @(negedge clk);
      check("glitch_no_ferr", n_ferr - ferr0, 0);
      check("glitch_no_byte", rx_valid, 0);

      // Framing error: 0x3C with the stop bit low.
      ferr0 = n_ferr;
      send_frame(1'b0, 8'h3C, F_BIT_NS, 1'b0);
      t = fall_cyc;
      repeat (50) @(negedge clk);
      check("ferr_count", n_ferr - ferr0, 1);
      check("ferr_cycle", ferr_cyc, t + 3 + STOP_LAT);
      check("ferr_fifo_empty", rx_valid, 0);

      // Overrun: five bytes into a depth-4 FIFO with no consumer.
      rx_ready = 1'b0;
      ferr0 = n_ferr; ovr0 = n_ovr;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back(8'(i));
         send_frame(1'b0, 8'(i), F_BIT_NS, 1'b1);
      end
      t = fall_cyc;
      repeat (20) @(negedge clk);
      check("ovr_count", n_ovr - ovr0, 1);
      check("ovr_cycle", ovr_cyc, t + 3 + STOP_LAT);
      check("ovr_no_ferr", n_ferr - ferr0, 0);
      check("ovr_valid_held", rx_valid, 1);
      @(posedge clk); #1 rx_ready = 1'b1;
      wait_drain("ovr_drain", 50);
      @(posedge clk); #1 rx_ready = 1'b0;

      // Full FIFO with a pop on the 5th stop-sample cycle: push is accepted.
      ovr0 = n_ovr;
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), F_BIT_NS, 1'b1);
      fork
         send_frame(1'b0, 8'h05, F_BIT_NS, 1'b1);
         begin
            @(fall_ev);
            repeat (2 + STOP_LAT) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("fullpop_no_overrun", n_ovr - ovr0, 0);
      check("fullpop_remaining", exp_q.size(), 4);
      @(posedge clk); #1 rx_ready = 1'b1;
      wait_drain("fullpop_drain", 50);
      @(posedge clk); #1 rx_ready = 1'b0;

      // Reset mid-frame with one byte already queued.
      send_frame(1'b0, 8'h99, F_BIT_NS, 1'b1);
      repeat (10) @(negedge clk);
      check("pre_reset_valid", rx_valid, 1);
      fork
         send_frame(1'b0, 8'h81, F_BIT_NS, 1'b1);
         begin
            @(fall_ev);
            repeat (5 * 16 * F_TICK + 30) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            check("midrst_valid",   rx_valid,  0);
            check("midrst_busy",    rx_busy,   0);
            check("midrst_ferr",    frame_err, 0);
            check("midrst_overrun", overrun,   0);
            repeat (400) @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      repeat (10) @(posedge clk);
      #1 rx_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send_frame(1'b0, 8'h7E, F_BIT_NS, 1'b1);
      wait_drain("post_reset_drain", 50);

      // Baud margin: 32 random bytes at +2.5% and 32 at -2.5%.
      ferr0 = n_ferr; ovr0 = n_ovr;
      for (int dir = 0; dir < 2; dir++) begin
         bit_ns = F_BIT_NS / ((dir == 0) ? 1.025 : 0.975);
         for (int i = 0; i < 32; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(1'b0, b, bit_ns, 1'b1);
         end
      end
      wait_drain("margin_drain", 200);
      check("margin_ferr", n_ferr - ferr0, 0);
      check("margin_overrun", n_ovr - ovr0, 0);

      repeat (10) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
